// File: rtl/uart_pkg.sv
// uart_pkg: shared types, legal parameter ranges and parity helper
// for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // data is zero-extended by callers; zeros do not affect the XOR
  function automatic logic parity_calc(
    input logic [DATA_BITS_MAX-1:0] data,
    input logic                     odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: baud_tick-timed UART serialiser (start, data LSB-first, parity, stop).
// Parity bit present only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal parameter set");
  end

  tx_state_e            state;
  tx_state_e            state_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 tx_nxt;
  logic                 done_nxt;
  logic                 accept;
  logic                 last_data;
  logic                 last_stop;
  logic                 shift;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  assign tx_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign last_data = (bit_cnt == CW'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign shift     = baud_tick && (state == DATA) && !last_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      tx      <= tx_nxt;
      tx_done <= done_nxt;
      if (accept) begin
        shreg <= tx_data;
`ifdef UART_TX_PARITY_EN
        par_q <= parity_calc(DATA_BITS_MAX'(tx_data), 1'(PARITY_ODD));
`endif
      end else if (shift) begin
        shreg <= shreg >> 1;
      end
      if (baud_tick && state == START)
        bit_cnt <= '0;
      else if (shift)
        bit_cnt <= bit_cnt + 1'b1;
      // stop_cnt only advances between stop bits of a 2-stop frame
      if (state != STOP)
        stop_cnt <= 1'b0;
      else if (baud_tick && !last_stop)
        stop_cnt <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept)    state_nxt = ARM;
      ARM:    if (baud_tick) state_nxt = START;
      START:  if (baud_tick) state_nxt = DATA;
      DATA:
        if (baud_tick && last_data) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      PARITY: if (baud_tick) state_nxt = STOP;
      STOP:   if (baud_tick && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx_nxt is the bit belonging to the state being entered
  always_comb begin
    tx_nxt   = tx;
    done_nxt = 1'b0;
    if (baud_tick) begin
      unique case (state)
        ARM:   tx_nxt = 1'b0;
        START: tx_nxt = shreg[0];
        DATA: begin
`ifdef UART_TX_PARITY_EN
          tx_nxt = last_data ? par_q : shreg[1];
`else
          tx_nxt = last_data ? 1'b1 : shreg[1];
`endif
        end
        PARITY: tx_nxt = 1'b1;
        STOP: begin
          tx_nxt   = 1'b1;
          done_nxt = last_stop;
        end
        default: tx_nxt = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx instances (8N1 even, 5-bit 2-stop odd,
// 8-bit odd) checked against a frame-queue model and literal frames.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic [2:0] tvalid;
  logic [2:0] otx;
  logic [2:0] obusy;
  logic [2:0] ordy;
  logic [2:0] odone;
  logic [8:0] tdata [3];

  int   checks = 0;
  int   fails  = 0;
  logic chk_en = 1'b0;
  logic acc_on = 1'b0;
  int   acc    = 0;

  logic m_tx   [3];
  logic m_busy [3];
  logic m_done [3];
  bit   fb     [3][16];
  int   flen   [3];
  int   fpos   [3];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .tx_data(tdata[0][7:0]), .tx_valid(tvalid[0]), .tx_ready(ordy[0]),
    .tx(otx[0]), .tx_busy(obusy[0]), .tx_done(odone[0]));

  uart_tx #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .tx_data(tdata[1][4:0]), .tx_valid(tvalid[1]), .tx_ready(ordy[1]),
    .tx(otx[1]), .tx_busy(obusy[1]), .tx_done(odone[1]));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .tx_data(tdata[2][7:0]), .tx_valid(tvalid[2]), .tx_ready(ordy[2]),
    .tx(otx[2]), .tx_busy(obusy[2]), .tx_done(odone[2]));

  function automatic int db_of(input int c);
    return (c == 1) ? 5 : 8;
  endfunction

  function automatic int sb_of(input int c);
    return (c == 1) ? 2 : 1;
  endfunction

  function automatic bit odd_of(input int c);
    return (c == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // frame = start, data LSB-first, optional parity, stop bits
  task automatic load_frame(input int c, input logic [8:0] d);
    int n;
    bit p;
    p = odd_of(c);
    fb[c][0] = 1'b0;
    n = 1;
    for (int i = 0; i < db_of(c); i++) begin
      fb[c][n] = d[i];
      p = p ^ d[i];
      n++;
    end
`ifdef UART_TX_PARITY_EN
    fb[c][n] = p;
    n++;
`endif
    for (int j = 0; j < sb_of(c); j++) begin
      fb[c][n] = 1'b1;
      n++;
    end
    flen[c] = n;
    fpos[c] = 0;
  endtask

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        m_tx[c]   = 1'b1;
        m_busy[c] = 1'b0;
        m_done[c] = 1'b0;
        flen[c]   = 0;
        fpos[c]   = 0;
      end else begin
        m_done[c] = 1'b0;
        if (!m_busy[c]) begin
          if (tvalid[c]) begin
            load_frame(c, tdata[c]);
            m_busy[c] = 1'b1;
          end
        end else if (baud_tick) begin
          if (fpos[c] < flen[c]) begin
            m_tx[c] = fb[c][fpos[c]];
            fpos[c]++;
          end else begin
            m_busy[c] = 1'b0;
            m_done[c] = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      m_tx[c] = 1'b1; m_busy[c] = 1'b0; m_done[c] = 1'b0;
      flen[c] = 0; fpos[c] = 0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("ch%0d_tx", c), 32'(otx[c]), 32'(m_tx[c]));
          chk($sformatf("ch%0d_busy", c), 32'(obusy[c]), 32'(m_busy[c]));
          chk($sformatf("ch%0d_ready", c), 32'(ordy[c]), 32'(!m_busy[c]));
          chk($sformatf("ch%0d_done", c), 32'(odone[c]), 32'(m_done[c]));
        end
      end
      if (acc_on && tvalid[0] && ordy[0]) acc++;
    end
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (15) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic send(input int c, input logic [8:0] d);
    int k;
    k = 0;
    tdata[c]  = d;
    tvalid[c] = 1'b1;
    while (m_busy[c] && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    tvalid[c] = 1'b0;
    tdata[c]  = ~d;
    if (k >= 2000) bound_fail("send");
  endtask

  task automatic wait_fall(input int c, output bit ok);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (otx[c] !== 1'b0 && k < 2000);
    ok = (otx[c] === 1'b0);
  endtask

  // sample each bit mid-period, then expect tx_done right at frame end
  task automatic sample_frame(input int c, input string exp_s,
                              input string name);
    string s;
    bit    ok;
    wait_fall(c, ok);
    if (!ok) begin
      bound_fail(name);
      return;
    end
    s = "";
    for (int i = 0; i < exp_s.len(); i++) begin
      repeat (8) @(posedge clk);
      #1;
      if (otx[c] === 1'b1) s = {s, "1"};
      else s = {s, "0"};
      repeat (8) @(posedge clk);
    end
    #1;
    checks++;
    if (s != exp_s) begin
      fails++;
      $display("FAIL %s: got %s expected %s", name, s, exp_s);
    end
    chk({name, "_done_at_end"}, 32'(odone[c]), 32'd1);
  endtask

`ifdef UART_TX_PARITY_EN
  localparam string F_A5    = "01010010101";
  localparam string F_07    = "01110000011";
  localparam string F_A5ODD = "01010010111";
  localparam string F_55    = "01010101001";
  localparam string F_AA    = "00101010101";
  localparam string F_1F    = "011111011";
`else
  localparam string F_A5    = "0101001011";
  localparam string F_07    = "0111000001";
  localparam string F_A5ODD = "0101001011";
  localparam string F_55    = "0101010101";
  localparam string F_AA    = "0010101011";
  localparam string F_1F    = "01111111";
`endif

  initial begin
    int k;
    int n;
    bit ok;
    rst    = 1'b1;
    tvalid = '0;
    for (int c = 0; c < 3; c++) tdata[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(otx), 32'h7);
    chk("rst_busy", 32'(obusy), 32'h0);
    chk("rst_ready", 32'(ordy), 32'h7);
    chk("rst_done", 32'(odone), 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    fork
      sample_frame(0, F_A5, "t1_a5");
      send(0, 9'h0A5);
    join
    chk("t1_ready_back", 32'(ordy[0]), 32'd1);

    fork
      sample_frame(0, F_07, "t2_07_even");
      send(0, 9'h007);
    join
    fork
      sample_frame(2, F_A5ODD, "t2_a5_odd");
      send(2, 9'h0A5);
    join

    acc    = 0;
    acc_on = 1'b1;
    fork
      begin
        sample_frame(0, F_55, "t3_55");
        sample_frame(0, F_AA, "t3_aa");
      end
      begin
        k = 0;
        tdata[0]  = 9'h055;
        tvalid[0] = 1'b1;
        do begin @(posedge clk); #1; k++; end
        while (!m_busy[0] && k < 3000);
        tdata[0] = 9'h0AA;
        do begin @(posedge clk); #1; k++; end
        while (m_busy[0] && k < 3000);
        do begin @(posedge clk); #1; k++; end
        while (!m_busy[0] && k < 3000);
        tvalid[0] = 1'b0;
        if (k >= 3000) bound_fail("t3_drive");
      end
    join
    acc_on = 1'b0;
    chk("t3_accepts", 32'(acc), 32'd2);

    send(0, 9'h0FF);
    wait_fall(0, ok);
    if (!ok) bound_fail("t4_start");
    repeat (69) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_rst_tx", 32'(otx[0]), 32'd1);
    chk("t4_rst_busy", 32'(obusy[0]), 32'd0);
    chk("t4_rst_done", 32'(odone[0]), 32'd0);
    rst = 1'b0;
    fork
      sample_frame(0, F_A5, "t4_after_rst");
      send(0, 9'h0A5);
    join

    k = 0;
    do begin @(posedge clk); #2; k++; end
    while (!baud_tick && k < 100);
    tdata[0]  = 9'h05A;
    tvalid[0] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) tvalid[0] = 1'b0;
    end while (otx[0] !== 1'b0 && n < 100);
    chk("t5_start_delay", 32'(n), 32'd17);
    k = 0;
    do begin @(posedge clk); #1; k++; end
    while (m_busy[0] && k < 400);

    fork
      sample_frame(1, F_1F, "t6_db5_sb2");
      send(1, 9'h01F);
    join

    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
